// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
// Contents:
//   fetch_state_t  - fetch request FSM states (IDLE / REQ / DROP)
//   RV32I_NOP      - canonical NOP (addi x0,x0,0) shown to decode when idle
//   FETCH_ENTRY_W  - width of one instruction buffer entry {pc, instruction}
//   align_word()   - clears the byte-offset bits of an address
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, response will be kept
    DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_t;

  localparam logic [31:0] RV32I_NOP     = 32'h0000_0013;
  localparam int          FETCH_ENTRY_W = 64;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// In-order instruction buffer between fetch and decode.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   push_i         - write push_data_i at the tail
//   push_data_i    - entry to write
//   pop_i          - retire the head entry (ignored when empty)
//   flush_i        - discard every entry; wins over push and pop
//   count_next_o   - occupancy after the coming edge (lets the caller
//                    decide on a new request in the same cycle)
//   valid_o        - head entry is valid
//   head_o         - head entry, read straight from the storage flops
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_next_o,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             pop_eff;

  assign pop_eff = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_eff})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;
  assign valid_o      = (count_q != '0);
  assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word reads to the
// instruction memory and buffers returned words in order for decode.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   imem_read        - read request, held until imem_resp
//   imem_address     - word-aligned fetch address, stable while imem_read
//   imem_resp        - one-cycle pulse, imem_rdata valid
//   imem_rdata       - returned instruction word
//   redirect         - restart fetch at redirect_pc (flushes the buffer)
//   redirect_pc      - new fetch target, low two bits ignored
//   id_valid         - id_instruction / id_pc valid toward decode
//   id_ready         - decode accepts the head entry this cycle
//   id_instruction   - head instruction, NOP when !id_valid
//   id_pc            - PC of head instruction, 0 when !id_valid
module instruction_fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0060,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t             state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              addr_q, addr_d;
  logic                     new_req;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_valid;
  logic [CNT_W-1:0]         fifo_count_next;
  logic [FETCH_ENTRY_W-1:0] fifo_head;
  logic                     space;

  // Only a response to a live request is kept; a redirect in the same
  // cycle kills it, and responses in IDLE/DROP are stale.
  assign fifo_push = (state_q == REQ) && imem_resp && !redirect;
  // Redirect owns the buffer this cycle, so decode cannot pop.
  assign fifo_pop  = fifo_valid && id_ready && !redirect;

  // A new request is only allowed if its word is guaranteed a slot:
  // occupancy after this edge plus the new outstanding request must fit.
  assign space = (fifo_count_next < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    new_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = align_word(redirect_pc);
        if (space)    new_req = 1'b1;
      end
      REQ: begin
        if (redirect) begin
          pc_d = align_word(redirect_pc);
          // Without a response the bus request must complete untouched.
          if (imem_resp) new_req = 1'b1;
          else           state_d = DROP;
        end else if (imem_resp) begin
          pc_d = pc_q + 32'd4;
          if (space) new_req = 1'b1;
          else       state_d = IDLE;
        end
      end
      DROP: begin
        if (redirect) pc_d = align_word(redirect_pc);
        if (imem_resp) begin
          if (space) new_req = 1'b1;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_req) begin
      state_d = REQ;
      addr_d  = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  instr_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .push_data_i  ({pc_q, imem_rdata}),
    .pop_i        (fifo_pop),
    .flush_i      (redirect),
    .count_next_o (fifo_count_next),
    .valid_o      (fifo_valid),
    .head_o       (fifo_head)
  );

  assign imem_read      = (state_q != IDLE);
  assign imem_address   = addr_q;
  assign id_valid       = fifo_valid;
  assign id_instruction = fifo_valid ? fifo_head[31:0]  : RV32I_NOP;
  assign id_pc          = fifo_valid ? fifo_head[63:32] : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  int vectors     = 0;
  int miscompares = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, 32'd1);
    chk({tag, ".id_pc"}, id_pc, pc);
    chk({tag, ".id_instruction"}, id_instruction, ins);
    $display("  id  %s pc=%h ins=%h", tag, id_pc, id_instruction);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, ".imem_read"}, {31'b0, imem_read}, 32'd1);
    chk({tag, ".imem_address"}, imem_address, addr);
    $display("  req %s addr=%h", tag, imem_address);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, 32'd0);
    chk({tag, ".id_instruction"}, id_instruction, 32'h0000_0013);
    chk({tag, ".id_pc"}, id_pc, 32'h0);
  endtask

  // Serve the current request: check it, answer one cycle later.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk_req(tag, addr);
    step();
    chk({tag, ".addr_stable"}, imem_address, addr);
    imem_resp  = 1'b1;
    imem_rdata = data;
    step();
    imem_resp  = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Hold reset two edges, release; returns in the first REQ cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    chk("rst.imem_read", {31'b0, imem_read}, 32'd0);
    chk_empty("rst");
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_resp   = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;

    // 1: streaming fetch with decode always ready
    do_reset();
    serve("t1.f0", 32'h60, 32'h1111_0001);
    chk_id("t1.w0", 32'h60, 32'h1111_0001);
    serve("t1.f1", 32'h64, 32'h1111_0002);
    chk_id("t1.w1", 32'h64, 32'h1111_0002);
    serve("t1.f2", 32'h68, 32'h1111_0003);
    chk_id("t1.w2", 32'h68, 32'h1111_0003);
    chk_req("t1.next", 32'h6C);

    // 2: decode stalled, buffer fills, fetch stops, then resumes at 0x68
    id_ready = 1'b0;
    do_reset();
    serve("t2.f0", 32'h60, 32'h2222_0001);
    chk_id("t2.h0", 32'h60, 32'h2222_0001);
    serve("t2.f1", 32'h64, 32'h2222_0002);
    chk("t2.full.imem_read", {31'b0, imem_read}, 32'd0);
    step();
    step();
    chk("t2.stall.imem_read", {31'b0, imem_read}, 32'd0);
    chk_id("t2.h0b", 32'h60, 32'h2222_0001);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk_req("t2.resume", 32'h68);
    chk_id("t2.h1", 32'h64, 32'h2222_0002);

    // 3: redirect while a request is outstanding
    id_ready = 1'b1;
    do_reset();
    serve("t3.f0", 32'h60, 32'h3333_0001);
    chk_id("t3.w0", 32'h60, 32'h3333_0001);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1002;
    step();
    redirect    = 1'b0;
    chk_req("t3.drop", 32'h64);
    chk_empty("t3.drop");
    step();
    chk("t3.held", imem_address, 32'h64);
    imem_resp  = 1'b1;
    imem_rdata = 32'hBAD0_0003;
    step();
    imem_resp  = 1'b0;
    chk_empty("t3.after");
    serve("t3.f1", 32'h1000, 32'h3333_0002);
    chk_id("t3.w1", 32'h1000, 32'h3333_0002);

    // 4: redirect coincides with response
    do_reset();
    step();
    imem_resp   = 1'b1;
    imem_rdata  = 32'hBAD0_0004;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    imem_resp   = 1'b0;
    redirect    = 1'b0;
    chk_empty("t4.nopush");
    serve("t4.f0", 32'h2000, 32'h4444_0001);
    chk_id("t4.w0", 32'h2000, 32'h4444_0001);

    // 5: flush beats pop; address wrap at top of memory
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect    = 1'b0;
    chk_empty("t5.flush");
    chk_req("t5.drop", 32'h2004);
    imem_resp  = 1'b1;
    step();
    imem_resp  = 1'b0;
    serve("t5.f0", 32'hFFFF_FFFC, 32'h5555_0001);
    chk_id("t5.w0", 32'hFFFF_FFFC, 32'h5555_0001);
    chk_req("t5.wrap", 32'h0000_0000);

    // 6: reset during an outstanding request, late response ignored
    rst_n = 1'b0;
    step();
    chk("t6.imem_read", {31'b0, imem_read}, 32'd0);
    chk_empty("t6.rst");
    rst_n      = 1'b1;
    imem_resp  = 1'b1;
    imem_rdata = 32'hBAD0_0006;
    step();
    imem_resp  = 1'b0;
    chk_empty("t6.late");
    serve("t6.f0", 32'h60, 32'h6666_0001);
    chk_id("t6.w0", 32'h60, 32'h6666_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
